// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package serial_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_ctrl_nibble_add.sv
// Combinational 4-bit ripple slice; also exposes the carry into the top bit for overflow detection.
import serial_adder_pkg::*;

module nibble_add (
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout,
    output logic                c3
);

    logic [NIBBLE_W:0] c;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < int'(NIBBLE_W); i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout = c[NIBBLE_W];
        c3   = c[NIBBLE_W-1];
    end

endmodule : nibble_add

// File: rtl/serial_adder_ctrl.sv
// Wide adder built by time-multiplexing one 4-bit slice, LS nibble first, start/busy/done handshake.
// Optional subtract support is enabled by defining SERIAL_ADDER_SUB_EN.
import serial_adder_pkg::*;

module serial_adder_ctrl #(
    parameter int unsigned NUM_NIBBLES = 4
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            start,
    input  logic [NIBBLE_W*NUM_NIBBLES-1:0] op_a,
    input  logic [NIBBLE_W*NUM_NIBBLES-1:0] op_b,
    input  logic                            carry_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic                            sub,
`endif
    output logic                            busy,
    output logic                            done,
    output logic [NIBBLE_W*NUM_NIBBLES-1:0] sum,
    output logic                            carry_out,
    output logic                            overflow
);

    localparam int unsigned W     = NIBBLE_W * NUM_NIBBLES;
    localparam int unsigned IDX_W = (NUM_NIBBLES > 2) ? $clog2(NUM_NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, b_q;
    logic               carry_q;
    logic               sub_q;
    logic [IDX_W-1:0]   idx_q;

    logic               load_c, step_c, last_c;
    logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
    logic               cout_nib, c3_nib;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and datapath strobes
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        last_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_c  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step_c = 1'b1;
                if (idx_q == LAST_IDX) begin
                    last_c  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand nibble selection; subtraction feeds the inverted B nibble
    always_comb begin
        a_nib = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
        b_nib = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
        if (sub_q) b_nib = ~b_nib;
    end

    nibble_add u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (s_nib),
        .cout (cout_nib),
        .c3   (c3_nib)
    );

`ifdef SERIAL_ADDER_SUB_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)      sub_q <= 1'b0;
        else if (load_c) sub_q <= sub;
    end
`else
    assign sub_q = 1'b0;
`endif

    // Operand latch, carry flop, nibble index and result registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (load_c) begin
            a_q     <= op_a;
            b_q     <= op_b;
            idx_q   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            carry_q <= sub ? 1'b1 : carry_in;
`else
            carry_q <= carry_in;
`endif
        end else if (step_c) begin
            sum[NIBBLE_W*idx_q +: NIBBLE_W] <= s_nib;
            carry_q <= cout_nib;
            if (last_c) begin
                carry_out <= cout_nib;
                overflow  <= c3_nib ^ cout_nib;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    // Handshake flags follow the next state so they are valid right after each edge
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_d != IDLE);
            done <= (state_d == DONE);
        end
    end

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl with NUM_NIBBLES=4.
module tb_serial_adder_ctrl;

    logic        clk;
    logic        n_rst;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        carry_in;
    logic        sub;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        carry_out;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    serial_adder_ctrl #(.NUM_NIBBLES(4)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .carry_in  (carry_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait (bounded) for done; lat = edges after the start edge
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic sb, output int lat);
        op_a = a; op_b = b; carry_in = ci; sub = sb; start = 1'b1;
        cyc();
        start = 1'b0;
        op_a = 16'hDEAD; op_b = 16'hBEEF; carry_in = 1'b0; sub = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            cyc();
            lat++;
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0; start = 1'b0; op_a = '0; op_b = '0; carry_in = 1'b0; sub = 1'b0;
        #12;
        total++;
        if ({busy, done, sum, carry_out, overflow} !== 20'h0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b sum=%h co=%b ov=%b, need all zero",
                     busy, done, sum, carry_out, overflow);
        end
        n_rst = 1'b1;
        cyc();
    endtask

    task automatic test_carry_prop();
        int lat;
        op_a = 16'hFFFF; op_b = 16'h0001; carry_in = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b need 1", busy); end
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin cyc(); lat++; end
        total++;
        if (lat !== 4) begin bad++; $display("FAIL carry_latency: got %0d edges need 4", lat); end
        total++;
        if ({sum, carry_out, overflow} !== {16'h0000, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL carry_result: got sum=%h co=%b ov=%b need 0000 1 0", sum, carry_out, overflow);
        end
        cyc();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: got done=%b busy=%b after pulse need 0 0", done, busy);
        end
        total++;
        if (sum !== 16'h0000 || carry_out !== 1'b1) begin
            bad++;
            $display("FAIL result_hold: got sum=%h co=%b need 0000 1", sum, carry_out);
        end
        cyc();
    endtask

    task automatic test_overflow();
        int lat;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        total++;
        if ({sum, carry_out, overflow} !== {16'h8000, 1'b0, 1'b1} || lat !== 4) begin
            bad++;
            $display("FAIL signed_ovf: got sum=%h co=%b ov=%b lat=%0d need 8000 0 1 4",
                     sum, carry_out, overflow, lat);
        end
        cyc();
    endtask

    task automatic test_carry_in();
        int lat;
        run_op(16'h1234, 16'h4321, 1'b1, 1'b0, lat);
        total++;
        if ({sum, carry_out, overflow} !== {16'h5556, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL carry_in: got sum=%h co=%b ov=%b need 5556 0 0", sum, carry_out, overflow);
        end
        cyc();
    endtask

    task automatic test_busy_reject();
        int pulses;
        logic [15:0] res;
        op_a = 16'h0001; op_b = 16'h0001; carry_in = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        op_a = 16'hAAAA; op_b = 16'h5555; start = 1'b1;
        cyc();
        start = 1'b0;
        pulses = 0;
        res = 16'hxxxx;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) begin pulses++; res = sum; end
            cyc();
        end
        total++;
        if (pulses !== 1) begin bad++; $display("FAIL reject_pulses: got %0d need 1", pulses); end
        total++;
        if (res !== 16'h0002) begin bad++; $display("FAIL reject_result: got %h need 0002", res); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reject_idle: got busy=%b need 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        op_a = 16'h1111; op_b = 16'h2222; carry_in = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        #2 n_rst = 1'b0;
        #1;
        total++;
        if ({busy, done, sum, carry_out, overflow} !== 20'h0) begin
            bad++;
            $display("FAIL async_reset: got busy=%b done=%b sum=%h co=%b ov=%b need all zero",
                     busy, done, sum, carry_out, overflow);
        end
        #3 n_rst = 1'b1;
        cyc();
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, lat);
        total++;
        if (sum !== 16'h0007 || carry_out !== 1'b0 || lat !== 4) begin
            bad++;
            $display("FAIL post_reset_op: got sum=%h co=%b lat=%0d need 0007 0 4", sum, carry_out, lat);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        int t0, t1, n;
        op_a = 16'h0001; op_b = 16'h0002; carry_in = 1'b0; start = 1'b1;
        t0 = -1; t1 = -1; n = 0;
        while (t1 < 0 && n < 40) begin
            cyc();
            n++;
            if (done === 1'b1) begin
                if (t0 < 0) t0 = n;
                else        t1 = n;
            end
        end
        start = 1'b0;
        total++;
        if (t1 - t0 !== 6) begin
            bad++;
            $display("FAIL back_to_back: got period %0d (t0=%0d t1=%0d) need 6", t1 - t0, t0, t1);
        end
        total++;
        if (sum !== 16'h0003) begin bad++; $display("FAIL b2b_result: got %h need 0003", sum); end
        cyc();
        cyc();
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        int lat;
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
        total++;
        if ({sum, carry_out, overflow} !== {16'hFFFE, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL sub_borrow: got sum=%h co=%b ov=%b need fffe 0 0", sum, carry_out, overflow);
        end
        cyc();
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
        total++;
        if ({sum, carry_out, overflow} !== {16'h7FFF, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL sub_ovf: got sum=%h co=%b ov=%b need 7fff 1 1", sum, carry_out, overflow);
        end
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_carry_prop();
        test_overflow();
        test_carry_in();
        test_busy_reject();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
